recording_sequencer: RTL and testbench
======================================

Name: recording_sequencer

Overview:
- Records and plays back the user's key performance for the music box.
- While the top-level state is Make Recording (4), it samples the 6-bit music key every tick and run-length encodes key changes into a RAM as {key, duration} entries.
- While the state is Play Recording (3), it reads the entries back and drives the key stream to the tone generator with the recorded timing.
- Sole owner of the recording RAM port; sits between the state controller and the audio datapath.

Parameters:
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W entries.
- TICK_DIV, 500000, clock cycles per sample tick (10 ms at 50 MHz); minimum 4.

Ports:
- clock_50Mhz  in  1  system clock
- reset_n  in  1  reset
- state_in  in  5  top-level state code: 3 = Play Recording, 4 = Make Recording, others = inactive
- music_key_in  in  6  current key code; 0 = silence
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  16  entry {key[15:10], duration[9:0]}
- mem_we  out  1  write strobe, one cycle per entry
- mem_re  out  1  read strobe
- mem_rdata  in  16  read data; valid exactly 1 cycle after mem_re
- key_out  out  6  playback key
- key_valid  out  1  key_out is meaningful
- play_done  out  1  one-cycle pulse at the end of playback
- rec_full  out  1  RAM filled during the last/current recording
- rec_length  out  ADDR_W+1  number of stored entries

Behaviour:
- Reset: reset_n is asynchronous, active-low; the clock is clock_50Mhz. On reset, all outputs are 0, the FSM goes to IDLE, and rec_length = 0. rec_length is held across recordings and cleared only by reset or by starting a new recording.
- Tick counter:
  - Cleared when leaving IDLE for REC_RUN or PLAY_FETCH.
  - tick is asserted for one cycle when the count equals TICK_DIV-1; the counter then wraps to 0.
- FSM states: IDLE, REC_RUN, REC_FULL, REC_FLUSH, PLAY_FETCH, PLAY_LOAD, PLAY_HOLD, DONE.
- IDLE:
  - state_in == 4: clear wr_ptr, rec_full and rec_length; set dur = 0; go to REC_RUN.
  - state_in == 3: if rec_length == 0, pulse play_done and go to DONE; otherwise clear rd_ptr and go to PLAY_FETCH.
- REC_RUN, on each tick, sampling s = music_key_in:
  - dur == 0 (first tick): cur_key = s, dur = 1, no write.
  - s == cur_key and dur < 1023: dur++.
  - Otherwise (key change or saturation): on the next cycle, write {cur_key, dur} at wr_ptr with mem_we = 1 for one cycle; wr_ptr++; then cur_key = s, dur = 1. A held key longer than 1023 ticks therefore splits into consecutive entries with the same key.
  - If a write makes wr_ptr == DEPTH: set rec_full = 1 and go to REC_FULL (stop sampling).
  - state_in != 4: go to REC_FLUSH.
- REC_FLUSH (one cycle): if dur > 0 and wr_ptr < DEPTH, write the pending entry and increment wr_ptr. Then rec_length = wr_ptr; go to IDLE.
- REC_FULL: hold; when state_in != 4, set rec_length = DEPTH and go to IDLE.
- A write pending on the same cycle state_in drops is still committed before the flush.
- PLAY_FETCH: mem_addr = rd_ptr, mem_re = 1 for one cycle; go to PLAY_LOAD.
- PLAY_LOAD: key_out = mem_rdata[15:10], remaining = mem_rdata[9:0], key_valid = 1; go to PLAY_HOLD.
- PLAY_HOLD:
  - On each tick, remaining--.
  - When remaining reaches 0: rd_ptr++.
  - If rd_ptr == rec_length: key_out = 0, key_valid = 0, pulse play_done, go to DONE.
  - Otherwise go to PLAY_FETCH. The new key appears 2 cycles after the expiring tick; key_valid stays high across the boundary.
  - An entry with duration 0 (corrupt) is treated as 1.
- Abort: state_in != 3 in any PLAY_* state forces key_valid = 0, key_out = 0, no play_done, and return to IDLE on the next cycle.
- DONE: hold until state_in is neither 3 nor 4, then go to IDLE. This prevents auto-replay.
- Exclusivity: mem_we and mem_re are never asserted in the same cycle.

Test Plan:
- TICK_DIV = 4. Record keys 5,5,5,9,9,0 (one per tick), then drop state_in -> writes {5,3} at address 0 and {9,2} at 1; flush writes {0,1} at 2; rec_length = 3.
- Play back that recording -> key_out = 5 for 3 ticks, 9 for 2, 0 for 1 (key_valid high throughout); play_done pulses once; FSM in DONE until state_in = 0.
- Hold key 7 for 2050 ticks -> entries {7,1023}, {7,1023}, {7,4}; the split occurs at exactly tick 1024.
- ADDR_W = 2, alternating keys for 8 ticks -> 4 writes, rec_full = 1, no mem_we after the 4th write, rec_length = 4 after exit.
- Set state_in to 0 mid-playback during PLAY_HOLD of entry 1 -> key_valid = 0 the next cycle, no play_done; a replay restarts from address 0.
- Assert reset_n mid-record with a write pending -> all outputs 0 immediately, rec_length = 0; play request -> immediate play_done, no mem_re.

Source files
------------

// File: rtl/recording_sequencer_if.sv
// Recording RAM port bundle shared by the recording sequencer (master) and the RAM (slave).
// Read data is expected one cycle after mem_re.
interface recording_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [15:0]       mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re,
        output mem_rdata
    );
endinterface

// File: rtl/recording_sequencer.sv
// Records the music-box key stream as run-length {key, duration} entries in RAM
// and replays them to the tone generator with the recorded timing.
module recording_sequencer #(
    parameter int ADDR_W   = 10,
    parameter int TICK_DIV = 500000
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset_n,
    input  logic [4:0]            state_in,
    input  logic [5:0]            music_key_in,
    recording_sequencer_if.master mem,
    output logic [5:0]            key_out,
    output logic                  key_valid,
    output logic                  play_done,
    output logic                  rec_full,
    output logic [ADDR_W:0]       rec_length
);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [4:0]      ST_PLAY = 5'd3;
    localparam logic [4:0]      ST_REC  = 5'd4;
    localparam logic [9:0]      DUR_MAX = 10'd1023;

    typedef enum logic [2:0] {
        IDLE,
        REC_RUN,
        REC_FULL,
        REC_FLUSH,
        PLAY_FETCH,
        PLAY_LOAD,
        PLAY_HOLD,
        DONE
    } seqState_t;

    seqState_t         state_q;
    logic [CNT_W-1:0]  tickCnt_q, tickCnt_d;
    logic              tick;
    logic              tickClear;
    logic [ADDR_W:0]   wrPtr_q, rdPtr_q;
    logic [ADDR_W:0]   wrPtrNext, rdPtrNext;
    logic [5:0]        curKey_q;
    logic [9:0]        dur_q;
    logic [9:0]        remaining_q;
    logic [ADDR_W-1:0] memAddr_q;
    logic [15:0]       memWdata_q;
    logic              memWe_q, memRe_q;
    logic [5:0]        keyOut_q;
    logic              keyValid_q, playDone_q, recFull_q;
    logic [ADDR_W:0]   recLength_q;
    logic [9:0]        loadDur;

    assign wrPtrNext = wrPtr_q + PTR_ONE;
    assign rdPtrNext = rdPtr_q + PTR_ONE;
    assign tick      = (tickCnt_q == CNT_W'(TICK_DIV - 1));
    // A corrupt zero-length entry still plays for one tick.
    assign loadDur   = (mem.mem_rdata[9:0] == 10'd0) ? 10'd1 : mem.mem_rdata[9:0];

    // The sample tick restarts its phase whenever a recording or playback begins.
    always_comb begin
        tickClear = 1'b0;
        if (state_q == IDLE) begin
            if (state_in == ST_REC) begin
                tickClear = 1'b1;
            end else if (state_in == ST_PLAY && recLength_q != '0) begin
                tickClear = 1'b1;
            end
        end
        tickCnt_d = tick ? '0 : tickCnt_q + CNT_W'(1);
        if (tickClear) begin
            tickCnt_d = '0;
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            tickCnt_q <= '0;
        end else begin
            tickCnt_q <= tickCnt_d;
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            curKey_q    <= '0;
            dur_q       <= '0;
            remaining_q <= '0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            memWe_q     <= 1'b0;
            memRe_q     <= 1'b0;
            keyOut_q    <= '0;
            keyValid_q  <= 1'b0;
            playDone_q  <= 1'b0;
            recFull_q   <= 1'b0;
            recLength_q <= '0;
        end else begin
            memWe_q    <= 1'b0;
            memRe_q    <= 1'b0;
            playDone_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (state_in == ST_REC) begin
                        wrPtr_q     <= '0;
                        recFull_q   <= 1'b0;
                        recLength_q <= '0;
                        dur_q       <= '0;
                        state_q     <= REC_RUN;
                    end else if (state_in == ST_PLAY) begin
                        if (recLength_q == '0) begin
                            playDone_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            rdPtr_q   <= '0;
                            memAddr_q <= '0;
                            memRe_q   <= 1'b1;
                            state_q   <= PLAY_FETCH;
                        end
                    end
                end

                REC_RUN: begin
                    if (state_in != ST_REC) begin
                        state_q <= REC_FLUSH;
                    end else if (tick) begin
                        if (dur_q == 10'd0) begin
                            curKey_q <= music_key_in;
                            dur_q    <= 10'd1;
                        end else if (music_key_in == curKey_q && dur_q != DUR_MAX) begin
                            dur_q <= dur_q + 10'd1;
                        end else begin
                            // Key change or saturated run: commit the finished entry.
                            memWe_q    <= 1'b1;
                            memAddr_q  <= wrPtr_q[ADDR_W-1:0];
                            memWdata_q <= {curKey_q, dur_q};
                            wrPtr_q    <= wrPtrNext;
                            curKey_q   <= music_key_in;
                            dur_q      <= 10'd1;
                            if (wrPtrNext == DEPTH_V) begin
                                recFull_q <= 1'b1;
                                state_q   <= REC_FULL;
                            end
                        end
                    end
                end

                REC_FLUSH: begin
                    if (dur_q != 10'd0 && wrPtr_q < DEPTH_V) begin
                        memWe_q     <= 1'b1;
                        memAddr_q   <= wrPtr_q[ADDR_W-1:0];
                        memWdata_q  <= {curKey_q, dur_q};
                        wrPtr_q     <= wrPtrNext;
                        recLength_q <= wrPtrNext;
                    end else begin
                        recLength_q <= wrPtr_q;
                    end
                    state_q <= IDLE;
                end

                REC_FULL: begin
                    if (state_in != ST_REC) begin
                        recLength_q <= DEPTH_V;
                        state_q     <= IDLE;
                    end
                end

                PLAY_FETCH: begin
                    if (state_in != ST_PLAY) begin
                        keyValid_q <= 1'b0;
                        keyOut_q   <= '0;
                        state_q    <= IDLE;
                    end else begin
                        state_q <= PLAY_LOAD;
                    end
                end

                PLAY_LOAD: begin
                    if (state_in != ST_PLAY) begin
                        keyValid_q <= 1'b0;
                        keyOut_q   <= '0;
                        state_q    <= IDLE;
                    end else begin
                        keyOut_q    <= mem.mem_rdata[15:10];
                        remaining_q <= loadDur;
                        keyValid_q  <= 1'b1;
                        state_q     <= PLAY_HOLD;
                    end
                end

                PLAY_HOLD: begin
                    if (state_in != ST_PLAY) begin
                        keyValid_q <= 1'b0;
                        keyOut_q   <= '0;
                        state_q    <= IDLE;
                    end else if (tick) begin
                        if (remaining_q <= 10'd1) begin
                            remaining_q <= '0;
                            rdPtr_q     <= rdPtrNext;
                            if (rdPtrNext == recLength_q) begin
                                keyOut_q   <= '0;
                                keyValid_q <= 1'b0;
                                playDone_q <= 1'b1;
                                state_q    <= DONE;
                            end else begin
                                // key_valid stays high while the next entry is fetched.
                                memAddr_q <= rdPtrNext[ADDR_W-1:0];
                                memRe_q   <= 1'b1;
                                state_q   <= PLAY_FETCH;
                            end
                        end else begin
                            remaining_q <= remaining_q - 10'd1;
                        end
                    end
                end

                DONE: begin
                    if (state_in != ST_PLAY && state_in != ST_REC) begin
                        state_q <= IDLE;
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem.mem_addr  = memAddr_q;
    assign mem.mem_wdata = memWdata_q;
    assign mem.mem_we    = memWe_q;
    assign mem.mem_re    = memRe_q;
    assign key_out       = keyOut_q;
    assign key_valid     = keyValid_q;
    assign play_done     = playDone_q;
    assign rec_full      = recFull_q;
    assign rec_length    = recLength_q;

    // Writes and reads live in disjoint states, so the strobes never overlap.
    assert property (@(posedge clock_50Mhz) disable iff (!reset_n) !(memWe_q && memRe_q));

endmodule

// File: tb/tb_recording_sequencer.sv
// Directed bench for recording_sequencer with a small RAM (ADDR_W=2) and a 4-cycle tick.
// Records, plays back, splits long notes, fills the RAM, aborts playback and resets mid-record.
module tb_recording_sequencer;
    localparam int ADDR_W   = 2;
    localparam int TICK_DIV = 4;

    logic              clock_50Mhz = 1'b0;
    logic              reset_n;
    logic [4:0]        state_in;
    logic [5:0]        music_key_in;
    logic [5:0]        key_out;
    logic              key_valid;
    logic              play_done;
    logic              rec_full;
    logic [ADDR_W:0]   rec_length;

    int vectorCnt = 0;
    int missCnt   = 0;
    int cyc       = 0;
    int reCnt     = 0;
    int bothCnt   = 0;

    logic [15:0] wrData[$];
    int          wrAddr[$];
    int          wrCyc[$];
    logic [15:0] ram [0:(1<<ADDR_W)-1];

    typedef struct {
        logic [5:0]        key;
        logic              expWe;
        logic [ADDR_W-1:0] expAddr;
        logic [15:0]       expData;
    } recVec_t;

    recVec_t recVecs[6];

    recording_sequencer_if #(.ADDR_W(ADDR_W)) memIf();

    recording_sequencer #(.ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV)) dut (
        .clock_50Mhz (clock_50Mhz),
        .reset_n     (reset_n),
        .state_in    (state_in),
        .music_key_in(music_key_in),
        .mem         (memIf),
        .key_out     (key_out),
        .key_valid   (key_valid),
        .play_done   (play_done),
        .rec_full    (rec_full),
        .rec_length  (rec_length)
    );

    always #10 clock_50Mhz = ~clock_50Mhz;

    always @(posedge clock_50Mhz) cyc <= cyc + 1;

    // Recording RAM: read data valid one cycle after mem_re.
    always @(posedge clock_50Mhz) begin
        if (memIf.mem_we) ram[memIf.mem_addr] <= memIf.mem_wdata;
        if (memIf.mem_re) memIf.mem_rdata <= ram[memIf.mem_addr];
    end

    always @(negedge clock_50Mhz) begin
        if (memIf.mem_we) begin
            wrData.push_back(memIf.mem_wdata);
            wrAddr.push_back(int'(memIf.mem_addr));
            wrCyc.push_back(cyc);
        end
        if (memIf.mem_re) reCnt++;
        if (memIf.mem_we && memIf.mem_re) bothCnt++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectorCnt++;
        if (act !== exp) begin
            missCnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] key);
        @(negedge clock_50Mhz);
        music_key_in = key;
        repeat (TICK_DIV) @(posedge clock_50Mhz);
        #1;
    endtask

    function automatic logic [31:0] logData(input int i);
        return (i < wrData.size()) ? 32'(wrData[i]) : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] logAddr(input int i);
        return (i < wrAddr.size()) ? 32'(wrAddr[i]) : 32'hDEADBEEF;
    endfunction

    function automatic logic [31:0] logCyc(input int i);
        return (i < wrCyc.size()) ? 32'(wrCyc[i]) : 32'hDEADBEEF;
    endfunction

    task automatic clearLog();
        wrData.delete();
        wrAddr.delete();
        wrCyc.delete();
    endtask

    initial begin
        int   runKey[8];
        int   runLen[8];
        int   nRuns, doneCnt, gapCnt, weDuring, cyc0, reSnap;
        logic found;
        logic [15:0] expFull[4];

        recVecs[0] = '{6'd5, 1'b0, 2'd0, 16'h0000};
        recVecs[1] = '{6'd5, 1'b0, 2'd0, 16'h0000};
        recVecs[2] = '{6'd5, 1'b0, 2'd0, 16'h0000};
        recVecs[3] = '{6'd9, 1'b1, 2'd0, {6'd5, 10'd3}};
        recVecs[4] = '{6'd9, 1'b0, 2'd0, 16'h0000};
        recVecs[5] = '{6'd0, 1'b1, 2'd1, {6'd9, 10'd2}};
        expFull[0] = {6'd1, 10'd1};
        expFull[1] = {6'd2, 10'd1};
        expFull[2] = {6'd1, 10'd1};
        expFull[3] = {6'd2, 10'd1};

        reset_n      = 1'b0;
        state_in     = 5'd0;
        music_key_in = 6'd0;
        repeat (3) @(posedge clock_50Mhz);
        #1;
        checkOutput("reset_key_valid", 32'(key_valid), 0);
        checkOutput("reset_play_done", 32'(play_done), 0);
        checkOutput("reset_rec_length", 32'(rec_length), 0);
        checkOutput("reset_mem_we", 32'(memIf.mem_we), 0);
        checkOutput("reset_mem_re", 32'(memIf.mem_re), 0);
        @(negedge clock_50Mhz);
        reset_n = 1'b1;

        // Record 5,5,5,9,9,0 one per tick.
        clearLog();
        @(negedge clock_50Mhz);
        state_in = 5'd4;
        @(posedge clock_50Mhz);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(recVecs[i].key);
            checkOutput($sformatf("rec_we[%0d]", i), 32'(memIf.mem_we), 32'(recVecs[i].expWe));
            if (recVecs[i].expWe) begin
                checkOutput($sformatf("rec_addr[%0d]", i), 32'(memIf.mem_addr), 32'(recVecs[i].expAddr));
                checkOutput($sformatf("rec_data[%0d]", i), 32'(memIf.mem_wdata), 32'(recVecs[i].expData));
            end
        end
        @(negedge clock_50Mhz);
        state_in = 5'd0;
        repeat (2) @(posedge clock_50Mhz);
        #1;
        checkOutput("flush_we", 32'(memIf.mem_we), 1);
        checkOutput("flush_addr", 32'(memIf.mem_addr), 2);
        checkOutput("flush_data", 32'(memIf.mem_wdata), 32'({6'd0, 10'd1}));
        checkOutput("flush_rec_length", 32'(rec_length), 3);
        @(posedge clock_50Mhz);
        #1;
        checkOutput("flush_we_off", 32'(memIf.mem_we), 0);
        checkOutput("rec1_write_count", 32'(wrData.size()), 3);

        // Play it back and collect runs of key_out.
        nRuns = 0; doneCnt = 0; gapCnt = 0; weDuring = 0;
        @(negedge clock_50Mhz);
        state_in = 5'd3;
        for (int c = 0; c < 120; c++) begin
            @(posedge clock_50Mhz);
            #1;
            if (play_done) doneCnt++;
            if (memIf.mem_we) weDuring++;
            if (key_valid) begin
                if (nRuns == 0 || runKey[nRuns-1] != int'(key_out)) begin
                    if (nRuns < 8) begin
                        runKey[nRuns] = int'(key_out);
                        runLen[nRuns] = 1;
                        nRuns++;
                    end
                end else begin
                    runLen[nRuns-1]++;
                end
            end else if (nRuns != 0 && doneCnt == 0) begin
                gapCnt++;
            end
        end
        checkOutput("play_runs", 32'(nRuns), 3);
        checkOutput("play_key0", 32'(runKey[0]), 5);
        checkOutput("play_len0", 32'(runLen[0]), 12);
        checkOutput("play_key1", 32'(runKey[1]), 9);
        checkOutput("play_len1", 32'(runLen[1]), 8);
        checkOutput("play_key2", 32'(runKey[2]), 0);
        checkOutput("play_len2", 32'(runLen[2]), 2);
        checkOutput("play_valid_gaps", 32'(gapCnt), 0);
        checkOutput("play_done_pulses", 32'(doneCnt), 1);
        checkOutput("play_no_writes", 32'(weDuring), 0);
        checkOutput("done_key_valid", 32'(key_valid), 0);
        @(negedge clock_50Mhz);
        state_in = 5'd0;
        @(posedge clock_50Mhz);

        // Hold key 7 for 2050 ticks: split at tick 1024 and 2047.
        clearLog();
        @(negedge clock_50Mhz);
        state_in     = 5'd4;
        music_key_in = 6'd7;
        @(posedge clock_50Mhz);
        #1;
        cyc0 = cyc;
        repeat (2050 * TICK_DIV) @(posedge clock_50Mhz);
        @(negedge clock_50Mhz);
        state_in = 5'd0;
        repeat (4) @(posedge clock_50Mhz);
        #1;
        checkOutput("hold_write_count", 32'(wrData.size()), 3);
        checkOutput("hold_data0", logData(0), 32'({6'd7, 10'd1023}));
        checkOutput("hold_data1", logData(1), 32'({6'd7, 10'd1023}));
        checkOutput("hold_data2", logData(2), 32'({6'd7, 10'd4}));
        checkOutput("hold_addr2", logAddr(2), 2);
        checkOutput("hold_split_cycle0", logCyc(0) - 32'(cyc0), 4096);
        checkOutput("hold_split_cycle1", logCyc(1) - 32'(cyc0), 8188);
        checkOutput("hold_rec_length", 32'(rec_length), 3);

        // Alternate keys for 8 ticks into a 4-entry RAM.
        clearLog();
        @(negedge clock_50Mhz);
        state_in = 5'd4;
        @(posedge clock_50Mhz);
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i % 2 == 0) ? 6'd1 : 6'd2);
        end
        checkOutput("full_flag", 32'(rec_full), 1);
        checkOutput("full_write_count", 32'(wrData.size()), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("full_data[%0d]", i), logData(i), 32'(expFull[i]));
            checkOutput($sformatf("full_addr[%0d]", i), logAddr(i), 32'(i));
        end
        @(negedge clock_50Mhz);
        state_in = 5'd0;
        repeat (2) @(posedge clock_50Mhz);
        #1;
        checkOutput("full_rec_length", 32'(rec_length), 4);
        checkOutput("full_flag_held", 32'(rec_full), 1);
        checkOutput("full_write_count_after", 32'(wrData.size()), 4);

        // Abort during the hold of entry 1, then replay from address 0.
        doneCnt = 0;
        found   = 1'b0;
        @(negedge clock_50Mhz);
        state_in = 5'd3;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clock_50Mhz);
            #1;
            if (play_done) doneCnt++;
            if (key_valid && key_out == 6'd2) found = 1'b1;
        end
        checkOutput("abort_reached_entry1", 32'(found), 1);
        @(negedge clock_50Mhz);
        state_in = 5'd0;
        @(posedge clock_50Mhz);
        #1;
        checkOutput("abort_key_valid", 32'(key_valid), 0);
        checkOutput("abort_key_out", 32'(key_out), 0);
        for (int c = 0; c < 6; c++) begin
            if (play_done) doneCnt++;
            @(posedge clock_50Mhz);
            #1;
        end
        checkOutput("abort_no_play_done", 32'(doneCnt), 0);
        @(negedge clock_50Mhz);
        state_in = 5'd3;
        @(posedge clock_50Mhz);
        #1;
        checkOutput("replay_mem_re", 32'(memIf.mem_re), 1);
        checkOutput("replay_addr", 32'(memIf.mem_addr), 0);
        found = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            @(posedge clock_50Mhz);
            #1;
            if (play_done) found = 1'b1;
        end
        checkOutput("replay_play_done", 32'(found), 1);
        @(negedge clock_50Mhz);
        state_in = 5'd0;
        @(posedge clock_50Mhz);

        // Reset while a recording write is in flight.
        @(negedge clock_50Mhz);
        state_in = 5'd4;
        @(posedge clock_50Mhz);
        applyStimulus(6'd3);
        applyStimulus(6'd3);
        applyStimulus(6'd4);
        checkOutput("prereset_we", 32'(memIf.mem_we), 1);
        #2;
        reset_n  = 1'b0;
        state_in = 5'd0;
        #1;
        checkOutput("areset_mem_we", 32'(memIf.mem_we), 0);
        checkOutput("areset_mem_addr", 32'(memIf.mem_addr), 0);
        checkOutput("areset_mem_wdata", 32'(memIf.mem_wdata), 0);
        checkOutput("areset_rec_length", 32'(rec_length), 0);
        checkOutput("areset_rec_full", 32'(rec_full), 0);
        checkOutput("areset_key_out", 32'(key_out), 0);
        @(negedge clock_50Mhz);
        reset_n = 1'b1;
        @(negedge clock_50Mhz);
        reSnap   = reCnt;
        doneCnt  = 0;
        state_in = 5'd3;
        @(posedge clock_50Mhz);
        #1;
        checkOutput("empty_play_done", 32'(play_done), 1);
        for (int c = 0; c < 6; c++) begin
            if (play_done) doneCnt++;
            @(posedge clock_50Mhz);
            #1;
        end
        checkOutput("empty_play_done_count", 32'(doneCnt), 1);
        checkOutput("empty_no_mem_re", 32'(reCnt - reSnap), 0);
        checkOutput("we_re_overlap", 32'(bothCnt), 0);
        @(negedge clock_50Mhz);
        state_in = 5'd0;
        repeat (2) @(posedge clock_50Mhz);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCnt, missCnt);
        $finish;
    end
endmodule
